// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB initiator bus for apb_cmd_master.
// The master modport is the bridge side; the slave modport is the requester/APB-target side.
interface apb_cmd_master_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_strb;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_error;
   logic              rsp_timeout;

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [STRB_W-1:0] pstrb;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
             psel, penable, pwrite, paddr, pwdata, pstrb
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
             psel, penable, pwrite, paddr, pwdata, pstrb
   );
endinterface

// File: rtl/apb_cmd_master.sv
// Bridges a command/response handshake onto single APB transfers, one outstanding.
// Define APB_TIMEOUT_EN to abort transfers after TIMEOUT ACCESS cycles without pready.
module apb_cmd_master #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input logic              clk,
   input logic              rst,
   apb_cmd_master_if.master bus
);
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state, state_nxt;
   logic   accept_c;
   logic   done_c;
   logic   tmo_hit_c;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("apb_cmd_master: TIMEOUT must be at least 1");
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               accept_c  = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP:  state_nxt = ACCESS;
         ACCESS: begin
            if (bus.pready) begin
               done_c    = 1'b1;
               state_nxt = RESP;
            end else if (tmo_hit_c) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and APB control are decoded from the next state so they leave a flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.cmd_ready <= 1'b1;
         bus.psel      <= 1'b0;
         bus.penable   <= 1'b0;
         bus.rsp_valid <= 1'b0;
      end else begin
         bus.cmd_ready <= (state_nxt == IDLE);
         bus.psel      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
         bus.penable   <= (state_nxt == ACCESS);
         bus.rsp_valid <= (state_nxt == RESP);
      end
   end

   // Address phase payload is frozen at accept; reads never drive strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.paddr  <= ADDR_W'(0);
         bus.pwrite <= 1'b0;
         bus.pwdata <= DATA_W'(0);
         bus.pstrb  <= STRB_W'(0);
      end else if (accept_c) begin
         bus.paddr  <= bus.cmd_addr;
         bus.pwrite <= bus.cmd_write;
         bus.pwdata <= bus.cmd_wdata;
         bus.pstrb  <= bus.cmd_write ? bus.cmd_strb : STRB_W'(0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rsp_rdata <= DATA_W'(0);
         bus.rsp_error <= 1'b0;
      end else if (done_c) begin
         bus.rsp_rdata <= bus.pwrite ? DATA_W'(0) : bus.prdata;
         bus.rsp_error <= bus.pslverr;
      end else if (tmo_hit_c) begin
         bus.rsp_rdata <= DATA_W'(0);
         bus.rsp_error <= 1'b1;
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;

   // Counts pready-low ACCESS cycles; held at zero outside ACCESS
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  wait_cnt <= CNT_W'(0);
      else if (state != ACCESS) wait_cnt <= CNT_W'(0);
      else if (!bus.pready)     wait_cnt <= wait_cnt + CNT_W'(1);
   end

   assign tmo_hit_c = (state == ACCESS) && !bus.pready &&
                      (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            bus.rsp_timeout <= 1'b0;
      else if (done_c)    bus.rsp_timeout <= 1'b0;
      else if (tmo_hit_c) bus.rsp_timeout <= 1'b1;
   end
`else
   assign tmo_hit_c       = 1'b0;
   assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: scoreboard of expected responses, per-cycle protocol checks.
module tb_apb_cmd_master;
   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } rsp_t;

   rsp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      for (int n = 0; n < 64 && bus.cmd_ready !== 1'b1; n++) tick();
      chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1'b1));
   endtask

   task automatic check_rsp(input string tag);
      rsp_t e;
      chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'(1'b1));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(1'b1));
         chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(e.rdata));
         chk({tag, "_rsp_error"}, 64'(bus.rsp_error), 64'(e.err));
         chk({tag, "_rsp_timeout"}, 64'(bus.rsp_timeout), 64'(e.tmo));
      end
   endtask

   // One transfer with nwait pready-low cycles; hold = RESP cycles with rsp_ready low
   task automatic do_xfer(input string tag, input logic w, input logic [11:0] a,
                          input logic [31:0] wd, input logic [3:0] st, input int nwait,
                          input logic err, input logic [31:0] rd, input int hold);
      rsp_t       e;
      logic [3:0] xs;
      e.rdata = w ? 32'h0 : rd;
      e.err   = err;
      e.tmo   = 1'b0;
      exp_q.push_back(e);
      xs = w ? st : 4'h0;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = wd;
      bus.cmd_strb  = st;
      bus.cmd_valid = 1'b1;
      bus.rsp_ready = (hold == 0);
      wait_idle(tag);
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_write = ~w;
      bus.cmd_addr  = ~a;
      bus.cmd_wdata = ~wd;
      bus.cmd_strb  = ~st;
      chk({tag, "_setup"}, 64'({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid}), 64'(4'b1000));
      for (int i = 0; i <= nwait; i++) begin
         tick();
         chk({tag, "_access"}, 64'({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid}), 64'(4'b1100));
         chk({tag, "_bus"}, 64'({bus.pwrite, bus.paddr, bus.pstrb, bus.pwdata}), 64'({w, a, xs, wd}));
         bus.pready  = (i == nwait);
         bus.pslverr = (i == nwait) ? err : 1'b1;
         bus.prdata  = (i == nwait) ? rd : 32'hdead_beef;
      end
      tick();
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h5a5a_5a5a;
      chk({tag, "_resp_ctl"}, 64'({bus.psel, bus.penable, bus.cmd_ready}), 64'(3'b000));
      check_rsp(tag);
      for (int i = 0; i < hold; i++) begin
         bus.cmd_valid = 1'b1;
         tick();
         chk({tag, "_hold_ctl"}, 64'({bus.rsp_valid, bus.psel, bus.cmd_ready}), 64'(3'b100));
         chk({tag, "_hold_data"}, 64'({bus.rsp_rdata, bus.rsp_error}), 64'({e.rdata, e.err}));
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      chk({tag, "_done"}, 64'({bus.rsp_valid, bus.psel, bus.cmd_ready}), 64'(3'b001));
   endtask

   // Transfer whose slave never answers, ended by an asynchronous reset pulse
   task automatic stuck_then_reset(input string tag, input int ncyc);
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 12'h018;
      bus.cmd_strb  = 4'hf;
      bus.cmd_valid = 1'b1;
      bus.rsp_ready = 1'b1;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b1;
      wait_idle(tag);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < ncyc; i++) begin
         chk({tag, "_waiting"}, 64'({bus.penable, bus.rsp_valid, bus.rsp_timeout}), 64'(3'b100));
         tick();
      end
      #2 rst = 1'b1;
      #1;
      chk({tag, "_async_rst"}, 64'({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid}), 64'(4'b0010));
      #2 rst = 1'b0;
      bus.pslverr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk({tag, "_no_rsp"}, 64'({bus.psel, bus.rsp_valid, bus.cmd_ready}), 64'(3'b001));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n_acc, rise0, rise1, n;
      logic prev, acc;
      rsp_t e;

      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 12'h0;
      bus.cmd_wdata = 32'h0;
      bus.cmd_strb  = 4'h0;
      bus.rsp_ready = 1'b0;
      bus.prdata    = 32'h0;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;

      tick();
      tick();
      chk("reset_ctl", 64'({bus.cmd_ready, bus.psel, bus.penable, bus.rsp_valid,
                            bus.rsp_error, bus.rsp_timeout}), 64'(6'b100000));
      chk("reset_bus", 64'({bus.pwrite, bus.paddr, bus.pstrb, bus.pwdata}), 64'(0));
      chk("reset_rdata", 64'(bus.rsp_rdata), 64'(0));
      #3 rst = 1'b0;
      tick();

      do_xfer("wr_tdr",   1'b1, 12'h00c, 32'h1234_5678, 4'hf, 0, 1'b0, 32'hcafe_f00d, 0);
      do_xfer("rd_tcr",   1'b0, 12'h000, 32'h0bad_0bad, 4'hf, 3, 1'b0, 32'h0000_0100, 0);
      do_xfer("wr_err",   1'b1, 12'h000, 32'h0000_0900, 4'h2, 0, 1'b1, 32'h0000_0000, 0);
      do_xfer("wr_strb0", 1'b1, 12'h01c, 32'h0000_00ff, 4'h0, 1, 1'b0, 32'h1111_1111, 0);
      do_xfer("rd_err",   1'b0, 12'h014, 32'h0,         4'h5, 2, 1'b1, 32'h0000_0042, 0);
      do_xfer("rd_hold",  1'b0, 12'h008, 32'h0,         4'hf, 0, 1'b0, 32'h8765_4321, 5);

      // Back-to-back commands with rsp_ready tied high
      bus.rsp_ready = 1'b1;
      bus.pready    = 1'b1;
      bus.pslverr   = 1'b0;
      bus.prdata    = 32'h0000_00a5;
      e = '{rdata: 32'h0, err: 1'b0, tmo: 1'b0};
      exp_q.push_back(e);
      e = '{rdata: 32'h0000_00a5, err: 1'b0, tmo: 1'b0};
      exp_q.push_back(e);
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 12'h004;
      bus.cmd_wdata = 32'h0000_0001;
      bus.cmd_strb  = 4'h3;
      bus.cmd_valid = 1'b1;
      wait_idle("b2b");
      n_acc = 0;
      rise0 = -1;
      rise1 = -1;
      prev  = 1'b0;
      for (int c = 0; c < 14; c++) begin
         acc = bus.cmd_valid && bus.cmd_ready;
         if (bus.psel && !prev) begin
            if (rise0 < 0) rise0 = c;
            else           rise1 = c;
         end
         prev = bus.psel;
         if (bus.psel || bus.rsp_valid) chk("b2b_cmd_ready_low", 64'(bus.cmd_ready), 64'(1'b0));
         if (bus.rsp_valid) check_rsp("b2b");
         tick();
         if (acc) begin
            n_acc++;
            if (n_acc == 1) begin
               bus.cmd_write = 1'b0;
               bus.cmd_addr  = 12'h008;
               bus.cmd_wdata = 32'hffff_ffff;
               bus.cmd_strb  = 4'hf;
            end else begin
               bus.cmd_valid = 1'b0;
            end
         end
      end
      chk("b2b_accepts", 64'(n_acc), 64'(2));
      chk("b2b_psel_gap", 64'(rise1 - rise0), 64'(4));
      bus.pready = 1'b0;

      // pready on the last cycle before the timeout limit completes normally
      do_xfer("limit_ready", 1'b0, 12'h010, 32'h0, 4'hf, 15, 1'b0, 32'h0000_0777, 0);

`ifdef APB_TIMEOUT_EN
      e = '{rdata: 32'h0, err: 1'b1, tmo: 1'b1};
      exp_q.push_back(e);
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 12'h014;
      bus.cmd_strb  = 4'hf;
      bus.cmd_valid = 1'b1;
      bus.rsp_ready = 1'b1;
      bus.pready    = 1'b0;
      bus.prdata    = 32'h1357_9bdf;
      wait_idle("tmo");
      tick();
      bus.cmd_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 40 && !bus.rsp_valid; c++) begin
         if (bus.penable) n++;
         tick();
      end
      chk("tmo_access_cycles", 64'(n), 64'(TIMEOUT));
      check_rsp("tmo");
      tick();
      chk("tmo_done", 64'({bus.rsp_valid, bus.cmd_ready}), 64'(2'b01));
      stuck_then_reset("rst_mid", 5);
`else
      stuck_then_reset("rst_mid", 20);
`endif

      do_xfer("post_rst", 1'b0, 12'h00c, 32'h0, 4'hf, 15, 1'b0, 32'h0000_2468, 0);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
